// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state/operator types and key codes for the calculator front end
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_OP = 3'd1,
    ENTER_B  = 3'd2,
    EXEC     = 3'd3,
    SHOW     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } op_t;

  localparam logic [3:0] KEY_OP    = 4'd8;
  localparam logic [3:0] KEY_ENTER = 4'd9;

  // keys 0..7 toggle the operand bit of the same index
  function automatic logic is_bit_key(input logic [3:0] idx);
    return (idx[3] == 1'b0);
  endfunction

  // one-hot mask for a bit key
  function automatic logic [7:0] bit_mask(input logic [3:0] idx);
    return 8'd1 << idx[2:0];
  endfunction

endpackage

// File: rtl/pb_cond.sv
// rtl/pb_cond.sv - pushbutton synchronizer, sampler and single-key event selector
module pb_cond #(
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [9:0] pb,
  output logic       key_valid,
  output logic [3:0] key_idx
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [9:0]    pb_s1;
  logic [9:0]    pb_s2;
  logic [9:0]    pb_q;
  logic [9:0]    pb_prev;
  logic [9:0]    key_evt;
  logic [CW-1:0] cnt;
  logic          tick;
  logic          tick_d;

  assign tick = (cnt == CNT_LAST);

  // two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pb_s1 <= '0;
      pb_s2 <= '0;
    end else begin
      pb_s1 <= pb;
      pb_s2 <= pb_s1;
    end
  end

  // free-running counter that sets the button sample rate
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // take a new sample on each tick and keep the previous one for edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pb_q    <= '0;
      pb_prev <= '0;
      tick_d  <= 1'b0;
    end else begin
      tick_d <= tick;
      if (tick) begin
        pb_q    <= pb_s2;
        pb_prev <= pb_q;
      end
    end
  end

  // a press is a 0->1 between consecutive samples, seen only the cycle after a tick
  always_comb begin
    key_evt = '0;
    if (tick_d) begin
      key_evt = pb_q & ~pb_prev;
    end
  end

  // lowest index wins when several keys rise in the same sample; others are dropped
  always_comb begin
    key_valid = 1'b0;
    key_idx   = '0;
    for (int i = 9; i >= 0; i--) begin
      if (key_evt[i]) begin
        key_valid = 1'b1;
        key_idx   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - calculator entry sequencer, ALU handshake and result hold
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [9:0] pb,
  output logic       alu_req,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_op,
  input  logic       alu_ack,
  input  logic [7:0] alu_result,
  input  logic       alu_err,
  output logic [7:0] disp_val,
  output logic [2:0] state_o,
  output logic       red,
  output logic       blue
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n;
  logic [7:0]    a, a_n;
  logic [7:0]    b, b_n;
  op_t           op, op_n;
  logic [7:0]    result, result_n;
  logic          err, err_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          key_valid;
  logic [3:0]    key_idx;

  pb_cond #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_pb_cond (
    .clk      (clk),
    .n_rst    (n_rst),
    .pb       (pb),
    .key_valid(key_valid),
    .key_idx  (key_idx)
  );

  // state, operand, result and timeout registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= ENTER_A;
      a      <= '0;
      b      <= '0;
      op     <= OP_ADD;
      result <= '0;
      err    <= 1'b0;
      tcnt   <= '0;
    end else begin
      state  <= state_n;
      a      <= a_n;
      b      <= b_n;
      op     <= op_n;
      result <= result_n;
      err    <= err_n;
      tcnt   <= tcnt_n;
    end
  end

  // next-state and register updates driven by key events and the ALU handshake
  always_comb begin
    state_n  = state;
    a_n      = a;
    b_n      = b;
    op_n     = op;
    result_n = result;
    err_n    = err;
    tcnt_n   = tcnt;
    case (state)
      ENTER_A: begin
        if (key_valid) begin
          if (is_bit_key(key_idx)) begin
            a_n = a ^ bit_mask(key_idx);
          end else if (key_idx == KEY_ENTER) begin
            state_n = ENTER_OP;
          end
        end
      end
      ENTER_OP: begin
        if (key_valid) begin
          if (key_idx == KEY_OP) begin
            op_n = op_t'(op + 2'd1);
          end else if (key_idx == KEY_ENTER) begin
            state_n = ENTER_B;
          end
        end
      end
      ENTER_B: begin
        if (key_valid) begin
          if (is_bit_key(key_idx)) begin
            b_n = b ^ bit_mask(key_idx);
          end else if (key_idx == KEY_ENTER) begin
            tcnt_n  = '0;
            state_n = EXEC;
          end
        end
      end
      EXEC: begin
        // an ack on the final waiting cycle still wins over the timeout
        if (alu_ack) begin
          result_n = alu_result;
          err_n    = alu_err;
          state_n  = SHOW;
        end else if (tcnt == TCNT_LAST) begin
          result_n = '0;
          err_n    = 1'b1;
          state_n  = SHOW;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      SHOW: begin
        if (key_valid) begin
          if (key_idx == KEY_ENTER) begin
            a_n     = result;
            b_n     = '0;
            state_n = ENTER_A;
          end else if (key_idx == KEY_OP) begin
            a_n     = '0;
            b_n     = '0;
            op_n    = OP_ADD;
            state_n = ENTER_A;
          end
        end
      end
      default: begin
        state_n = ENTER_A;
      end
    endcase
  end

  // outputs decoded from registered state only
  always_comb begin
    alu_req = (state == EXEC);
    alu_a   = a;
    alu_b   = b;
    alu_op  = op;
    state_o = state;
    red     = (state == SHOW) && err;
    blue    = (state == SHOW);
    case (state)
      ENTER_A:  disp_val = a;
      ENTER_OP: disp_val = {6'b0, op};
      ENTER_B:  disp_val = b;
      EXEC:     disp_val = b;
      SHOW:     disp_val = result;
      default:  disp_val = '0;
    endcase
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// tb/tb_calc_ctrl.sv - self-checking bench for calc_ctrl against a behavioural model
module tb_calc_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [9:0] pb = '0;
  logic       alu_ack = 1'b0;
  logic [7:0] alu_result = '0;
  logic       alu_err = 1'b0;
  logic       alu_req;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_op;
  logic [7:0] disp_val;
  logic [2:0] state_o;
  logic       red;
  logic       blue;

  calc_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .pb        (pb),
    .alu_req   (alu_req),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_ack   (alu_ack),
    .alu_result(alu_result),
    .alu_err   (alu_err),
    .disp_val  (disp_val),
    .state_o   (state_o),
    .red       (red),
    .blue      (blue)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: buttons are seen two clocks late, sampled every DEB clocks
  int         m_state;
  logic [7:0] m_a, m_b, m_res;
  logic [1:0] m_op;
  logic       m_err;
  int         m_wait;
  int         m_ecnt;
  logic [9:0] m_h1, m_h2, m_samp;
  logic       m_pend;
  int         m_pidx;
  int         m_evt_cnt = 0;

  task automatic model_reset();
    m_state = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_err = 1'b0;
    m_wait = 0; m_ecnt = 0; m_h1 = '0; m_h2 = '0; m_samp = '0;
    m_pend = 1'b0; m_pidx = 0;
  endtask

  task automatic model_step();
    logic [9:0] rising;
    case (m_state)
      0: if (m_pend) begin
           if (m_pidx < 8) m_a = m_a ^ 8'(1 << m_pidx);
           else if (m_pidx == 9) m_state = 1;
         end
      1: if (m_pend) begin
           if (m_pidx == 8) m_op = m_op + 2'd1;
           else if (m_pidx == 9) m_state = 2;
         end
      2: if (m_pend) begin
           if (m_pidx < 8) m_b = m_b ^ 8'(1 << m_pidx);
           else if (m_pidx == 9) begin m_state = 3; m_wait = 0; end
         end
      3: if (alu_ack) begin
           m_res = alu_result; m_err = alu_err; m_state = 4;
         end else begin
           m_wait++;
           if (m_wait == TMO) begin m_res = '0; m_err = 1'b1; m_state = 4; end
         end
      default: if (m_pend) begin
           if (m_pidx == 9) begin m_a = m_res; m_b = '0; m_state = 0; end
           else if (m_pidx == 8) begin m_a = '0; m_b = '0; m_op = '0; m_state = 0; end
         end
    endcase
    m_pend = 1'b0;
    m_ecnt++;
    if (m_ecnt % DEB == 0) begin
      rising = m_h2 & ~m_samp;
      m_samp = m_h2;
      for (int i = 9; i >= 0; i--) begin
        if (rising[i]) begin m_pend = 1'b1; m_pidx = i; end
      end
      if (m_pend) m_evt_cnt++;
    end
    m_h2 = m_h1;
    m_h1 = pb;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge n_rst);
      if (!n_rst) model_reset();
      else model_step();
    end
  end

  function automatic logic [7:0] exp_disp();
    case (m_state)
      0: return m_a;
      1: return {6'b0, m_op};
      2, 3: return m_b;
      default: return m_res;
    endcase
  endfunction

  // every-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      check("state_o", 32'(state_o), 32'(m_state));
      check("disp_val", 32'(disp_val), 32'(exp_disp()));
      check("alu_req", 32'(alu_req), 32'(m_state == 3));
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
      check("alu_op", 32'(alu_op), 32'(m_op));
      check("blue", 32'(blue), 32'(m_state == 4));
      check("red", 32'(red), 32'((m_state == 4) && m_err));
    end
  end

  // ALU stand-in: answers each request after a fixed or random latency
  int lat_fixed = 0;
  bit no_ack    = 1'b0;
  int late_req  = 0;

  initial begin
    int         late_done;
    int         lat;
    logic [8:0] s;
    late_done = 0;
    forever begin
      @(negedge clk);
      if (late_req != late_done) begin
        late_done  = late_req;
        alu_ack    = 1'b1;
        alu_result = 8'hFF;
        alu_err    = 1'b0;
        @(negedge clk);
        alu_ack = 1'b0;
      end else if (alu_req && !no_ack) begin
        lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 26));
        case (alu_op)
          2'd0: s = {1'b0, alu_a} + {1'b0, alu_b};
          2'd1: s = {1'b0, alu_a} - {1'b0, alu_b};
          2'd2: s = {1'b0, alu_a & alu_b};
          default: s = {1'b0, alu_a | alu_b};
        endcase
        repeat (lat - 1) @(negedge clk);
        alu_ack    = 1'b1;
        alu_result = s[7:0];
        alu_err    = s[8];
        @(negedge clk);
        alu_ack = 1'b0;
        for (int k = 0; k < 50 && alu_req; k++) @(negedge clk);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int i);
    pb[i] = 1'b1;
    tick(8);
    pb[i] = 1'b0;
    tick(8);
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int k;
    k = 0;
    while (int'(state_o) != st && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(state_o), 32'(st));
  endtask

  initial begin
    int k;
    int r;
    int hold;
    int gap;
    logic [9:0] mask;

    tick(3);
    n_rst = 1'b1;
    tick(1);
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_disp", 32'(disp_val), 32'd0);
    check("reset_req", 32'(alu_req), 32'd0);

    // one long hold gives a single toggle
    pb[3] = 1'b1;
    tick(40);
    pb[3] = 1'b0;
    tick(8);
    check("hold_disp", 32'(disp_val), 32'h08);
    check("hold_state", 32'(state_o), 32'd0);
    check("hold_model_a", 32'(m_a), 32'h08);
    check("hold_model_events", 32'(m_evt_cnt), 32'd1);

    // full ADD 05 + 03
    press(3);
    press(0);
    press(2);
    check("a_05", 32'(disp_val), 32'h05);
    press(9);
    check("to_op", 32'(state_o), 32'd1);
    press(9);
    check("to_b", 32'(state_o), 32'd2);
    press(0);
    press(1);
    check("b_03", 32'(disp_val), 32'h03);
    lat_fixed = 3;
    pb[9] = 1'b1;
    wait_state(3, 12, "enter_exec");
    check("exec_req", 32'(alu_req), 32'd1);
    check("exec_a", 32'(alu_a), 32'h05);
    check("exec_b", 32'(alu_b), 32'h03);
    check("exec_op", 32'(alu_op), 32'd0);
    wait_state(4, 10, "exec_to_show");
    check("add_disp", 32'(disp_val), 32'h08);
    check("add_blue", 32'(blue), 32'd1);
    check("add_red", 32'(red), 32'd0);
    check("add_req", 32'(alu_req), 32'd0);
    pb[9] = 1'b0;
    tick(8);

    // clear, then operator wrap after five KEY_OP presses
    press(8);
    check("clear_state", 32'(state_o), 32'd0);
    check("clear_disp", 32'(disp_val), 32'd0);
    press(9);
    for (int i = 0; i < 5; i++) press(8);
    check("wrap_disp", 32'(disp_val), 32'h01);
    check("wrap_model_op", 32'(m_op), 32'd1);

    // timeout with no ack, then a stray late ack
    no_ack = 1'b1;
    press(9);
    pb[9] = 1'b1;
    wait_state(3, 12, "to_exec_timeout");
    k = 0;
    while (state_o == 3'd3 && k < 40) begin
      tick(1);
      k++;
    end
    check("timeout_len", 32'(k), 32'(TMO));
    check("timeout_disp", 32'(disp_val), 32'd0);
    check("timeout_red", 32'(red), 32'd1);
    pb[9] = 1'b0;
    tick(8);
    late_req++;
    tick(4);
    check("late_ack_disp", 32'(disp_val), 32'd0);
    check("late_ack_red", 32'(red), 32'd1);
    check("late_ack_state", 32'(state_o), 32'd4);
    no_ack = 1'b0;

    // chaining and clear
    press(8);
    press(0); press(2); press(9); press(9); press(0); press(1); press(9);
    wait_state(4, 20, "chain_show1");
    check("chain_res", 32'(disp_val), 32'h08);
    press(9);
    check("chain_state", 32'(state_o), 32'd0);
    check("chain_a", 32'(disp_val), 32'h08);
    press(9); press(9); press(9);
    wait_state(4, 20, "chain_show2");
    check("chain_res2", 32'(disp_val), 32'h08);
    press(8);
    check("clr_state", 32'(state_o), 32'd0);
    check("clr_a", 32'(disp_val), 32'd0);

    // simultaneous rise: lowest index wins
    pb[1] = 1'b1;
    pb[6] = 1'b1;
    tick(8);
    pb = '0;
    tick(8);
    check("simul_disp", 32'(disp_val), 32'h02);
    press(9);
    check("clr_op", 32'(disp_val), 32'd0);
    press(9);

    // asynchronous reset in the middle of EXEC
    no_ack = 1'b1;
    pb[9] = 1'b1;
    wait_state(3, 12, "rst_exec");
    tick(3);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_req", 32'(alu_req), 32'd0);
    check("async_state", 32'(state_o), 32'd0);
    pb = '0;
    tick(2);
    n_rst = 1'b1;
    tick(2);
    check("post_rst_state", 32'(state_o), 32'd0);
    check("post_rst_disp", 32'(disp_val), 32'd0);
    no_ack = 1'b0;

    // randomized key traffic with random ALU latency
    lat_fixed = 0;
    for (int it = 0; it < 200; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50)      mask = 10'(1 << $urandom_range(0, 7));
      else if (r < 75) mask = 10'h200;
      else if (r < 90) mask = 10'h100;
      else             mask = 10'($urandom);
      hold = int'($urandom_range(1, 12));
      gap  = int'($urandom_range(1, 12));
      pb = mask;
      tick(hold);
      pb = '0;
      tick(gap);
    end
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
